sobel_grad_pipe: RTL

- Parametrised, pipelined Sobel gradient engine. Successor to the combinational kernel-coefficient negate/shift stage.
- Accepts one 3x3 pixel window per handshake. Applies the Gx and Gy kernel weights (negate, x2 shift), sums them, and produces a saturated |Gx|+|Gy| magnitude.
- Sits between the line-buffer/window generator and the display/threshold path, in the real-time edge-detect datapath.

---
 rtl/sobel_grad_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sobel_grad_pipe.sv
// sobel_grad_pipe: 3-stage pipelined Sobel gradient, saturated |Gx|+|Gy| magnitude with gradient signs
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_win/in_last window input;
// out_valid/out_ready/out_mag/out_last/out_gx_neg/out_gy_neg result output.
// SOBEL_THRESH_EN adds thresh input and registered out_edge = (out_mag >= thresh).
module sobel_grad_pipe #(
    parameter int DW = 8,
    parameter int OW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [9*DW-1:0] in_win,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_mag,
    output logic            out_last,
    output logic            out_gx_neg,
    output logic            out_gy_neg
`ifdef SOBEL_THRESH_EN
    ,
    input  logic [OW-1:0]   thresh,
    output logic            out_edge
`endif
);
    localparam int gw = DW + 3;
    localparam logic [gw-1:0] sat_max = {gw{1'b1}} >> (gw - OW);

    function automatic logic [gw-1:0] one(input logic [DW-1:0] v);
        return {3'b000, v};
    endfunction

    function automatic logic [gw-1:0] dbl(input logic [DW-1:0] v);
        return {2'b00, v, 1'b0};
    endfunction

    logic          en;
    logic [DW-1:0] p [9];
    logic [gw-1:0] tx [6];
    logic [gw-1:0] ty [6];
    logic          v1, l1, v2, l2;
    logic [gw-1:0] x1 [6];
    logic [gw-1:0] y1 [6];
    logic [gw-1:0] gx_c, gy_c, gx, gy;
    logic [gw-1:0] ax, ay, sum;
    logic [OW-1:0] mag_c;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        for (int i = 0; i < 9; i++) p[i] = in_win[i*DW +: DW];
        tx[0] = one(p[2]);
        tx[1] = dbl(p[5]);
        tx[2] = one(p[8]);
        tx[3] = -one(p[0]);
        tx[4] = -dbl(p[3]);
        tx[5] = -one(p[6]);
        ty[0] = one(p[6]);
        ty[1] = dbl(p[7]);
        ty[2] = one(p[8]);
        ty[3] = -one(p[0]);
        ty[4] = -dbl(p[1]);
        ty[5] = -one(p[2]);
    end

    always_comb begin
        gx_c = '0;
        gy_c = '0;
        for (int i = 0; i < 6; i++) begin
            gx_c = gx_c + x1[i];
            gy_c = gy_c + y1[i];
        end
    end

    // |Gx|+|Gy| cannot exceed 8*(2^DW-1), so the DW+3 bit sum never wraps
    always_comb begin
        ax    = gx[gw-1] ? -gx : gx;
        ay    = gy[gw-1] ? -gy : gy;
        sum   = ax + ay;
        mag_c = (sum > sat_max) ? '1 : sum[OW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                x1[i] <= '0;
                y1[i] <= '0;
            end
            v2         <= 1'b0;
            l2         <= 1'b0;
            gx         <= '0;
            gy         <= '0;
            out_valid  <= 1'b0;
            out_mag    <= '0;
            out_last   <= 1'b0;
            out_gx_neg <= 1'b0;
            out_gy_neg <= 1'b0;
`ifdef SOBEL_THRESH_EN
            out_edge   <= 1'b0;
`endif
        end else if (en) begin
            v1 <= in_valid;
            l1 <= in_last;
            for (int i = 0; i < 6; i++) begin
                x1[i] <= tx[i];
                y1[i] <= ty[i];
            end
            v2         <= v1;
            l2         <= l1;
            gx         <= gx_c;
            gy         <= gy_c;
            out_valid  <= v2;
            out_mag    <= mag_c;
            out_last   <= l2;
            out_gx_neg <= gx[gw-1];
            out_gy_neg <= gy[gw-1];
`ifdef SOBEL_THRESH_EN
            out_edge   <= mag_c >= thresh;
`endif
        end
    end
endmodule
